decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipelined RV32I instruction decoder for the next-generation core; replaces the state-gated decoder of the multi-cycle machine.
- Sits between fetch and execute.
- Accepts one raw instruction plus PC per valid/ready handshake and produces a registered control bundle.
- Buffers up to two decoded instructions (skid buffer), so in_ready is registered and back-pressure does not form a combinational path.
- Supports the full RV32I base set, optional M-extension decode and illegal-instruction flagging.

Parameters:
XLEN, 32, datapath/immediate/PC width; immediates sign-extend to XLEN.
ENABLE_M, 0, 1 = decode MUL/DIV/REM (opcode 0110011, funct7 0000001); 0 = flag them illegal.
ALU_CTL_W, 5, width of alu_ctl.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instr_raw/pc_in valid
in_ready  out  1  stage can accept (registered)
instr_raw  in  32  fetched instruction
pc_in  in  XLEN  PC of instr_raw
flush  in  1  discard all buffered entries (branch redirect)
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head
pc  out  XLEN  PC of head
imm  out  XLEN  decoded immediate
alu_ctl  out  ALU_CTL_W  ALU operation
branch_c, branch_uc, branch_relative  out  1 each  conditional branch / jump / PC-relative target
mem_read, mem_write  out  1 each  load / store
mem_funct3  out  3  load/store size and sign (funct3 passthrough)
alu_src  out  1  1 = imm, 0 = reg2
pc_src  out  1  1 = ALU operand A is PC (auipc, jal)
reg_write  out  1  writes rd (forced 0 when rd = x0)
read_reg1, read_reg2, write_reg  out  5 each  rs1, rs2, rd of head
illegal  out  1  head entry is an unrecognised encoding

Behaviour:
- Reset (rst_n low, asynchronous): count=0, out_valid=0, in_ready=1, all bundle outputs 0, alu_ctl=31.
- Decode is combinational on instr_raw and captured into a buffer entry on push (in_valid & in_ready). Latency is 1 cycle: out_valid rises the cycle after the push into an empty buffer.
- Occupancy FSM:
  - EMPTY(0): push → ONE.
  - ONE(1): push only → TWO; pop only → EMPTY; push+pop → ONE, new entry becomes head next cycle.
  - TWO(2): pop → ONE; no push is possible because in_ready=0.
  - Pop = out_valid & out_ready.
  - in_ready = (next count < 2), registered; it is 0 exactly when the buffer holds 2 entries.
- Entries are popped in order. The head is entry 0; on pop, entry 1 shifts to head.
- Head outputs are held stable while out_valid & !out_ready.
- flush: next count=0, out_valid=0, in_ready=1. A push in the same cycle as flush is dropped. Flush has priority over push and pop.
- Opcodes (standard RV32I):
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111/f3 000, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Anything else, or reserved funct3/funct7 combinations, → illegal=1 and all side-effect controls 0 (reg_write, mem_*, branch_*).
- Immediates, all sign-extended to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: imm=0.
- alu_ctl codes:
  - AND 0, OR 1, ADD 2, XOR 3, SLL 4, SRL 5, SUB 6, SRA 7, GE 8, SLT 9, CHOOSEB 10, SLTU 11, LT 12, LTU 13, GEU 14, EQ 15, NE 16.
  - MUL 20, MULH 21, MULHSU 22, MULHU 23, DIV 24, DIVU 25, REM 26, REMU 27.
  - ZERO 31 for illegal.
- Per-class control:
  - Loads, stores, JALR, AUIPC: ADD.
  - LUI: CHOOSEB.
  - JAL: CHOOSEB, with pc_src=1.
  - Branches: compare by funct3 (BEQ→EQ, BNE→NE, BLT→LT, BGE→GE, BLTU→LTU, BGEU→GEU).
  - branch_uc=1 for JAL/JALR; branch_relative=0 only for JALR.
  - alu_src=0 for OP and BRANCH, else 1.
  - reg_write=1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd≠0.
- SRAI/SRLI/SLLI require funct7 ∈ {0000000, 0100000 (SRAI only)}; otherwise illegal.

Test Plan:
- Reset mid-stream with count=2 → next cycle out_valid=0, in_ready=1, alu_ctl=31; subsequent push of addi x1,x0,5 (0x00500093) → out_valid next cycle, imm=5, alu_ctl=2, reg_write=1, write_reg=1.
- Back-pressure: out_ready=0, push beq (0xFE000EE3) then jal (0x0000006F) → in_ready=0 after second push; release → beq popped first (branch_c=1, alu_ctl=15, imm=0xFFFFFFFC), then jal (branch_uc=1, alu_ctl=10, pc_src=1).
- Simultaneous push+pop in ONE for 20 cycles → count stays 1, in_ready stays 1, outputs match inputs in order.
- flush asserted while count=2 and in_valid=1 → next cycle out_valid=0; the flushed push never appears.
- mul x3,x1,x2 (0x022081B3): ENABLE_M=0 → illegal=1, reg_write=0, alu_ctl=31; ENABLE_M=1 → alu_ctl=20, reg_write=1.
- add x0,x1,x2 → reg_write=0. lui x5,0xFFFFF → imm=0xFFFFF000, alu_ctl=10. Opcode 0x7F → illegal=1, mem_write=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch-side handshake, the flush request and the execute-side
// control bundle of the decode stage into one interface.
//   master : driven by the surrounding pipeline (fetch/execute/redirect)
//   slave  : the decode stage itself
// Signals:
//   in_valid/in_ready/instr_raw/pc_in : fetch -> decode handshake
//   flush                             : discard everything buffered
//   out_valid/out_ready               : decode -> execute handshake
//   pc .. illegal                     : decoded control bundle of the head
// ---------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int ALU_CTL_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr_raw;
    logic [XLEN-1:0]      pc_in;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 branch_c;
    logic                 branch_uc;
    logic                 branch_relative;
    logic                 mem_read;
    logic                 mem_write;
    logic [2:0]           mem_funct3;
    logic                 alu_src;
    logic                 pc_src;
    logic                 reg_write;
    logic [4:0]           read_reg1;
    logic [4:0]           read_reg2;
    logic [4:0]           write_reg;
    logic                 illegal;

    modport master (
        output in_valid, instr_raw, pc_in, flush, out_ready,
        input  in_ready, out_valid, pc, imm, alu_ctl, branch_c, branch_uc,
               branch_relative, mem_read, mem_write, mem_funct3, alu_src,
               pc_src, reg_write, read_reg1, read_reg2, write_reg, illegal
    );

    modport slave (
        input  in_valid, instr_raw, pc_in, flush, out_ready,
        output in_ready, out_valid, pc, imm, alu_ctl, branch_c, branch_uc,
               branch_relative, mem_read, mem_write, mem_funct3, alu_src,
               pc_src, reg_write, read_reg1, read_reg2, write_reg, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Pipelined RV32I decoder with a two-entry skid buffer between fetch and
// execute. Each accepted instruction is decoded combinationally and stored
// as a complete control bundle; the head entry drives the outputs.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : decode_stage_if.slave (fetch handshake, flush, execute bundle)
// Parameters:
//   XLEN      : PC / immediate width
//   ENABLE_M  : 1 decodes MUL/DIV/REM, 0 flags them illegal
//   ALU_CTL_W : width of alu_ctl
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit ENABLE_M  = 1'b0,
    parameter int ALU_CTL_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic [ALU_CTL_W-1:0] alu_ctl;
        logic                 branch_c;
        logic                 branch_uc;
        logic                 branch_relative;
        logic                 mem_read;
        logic                 mem_write;
        logic [2:0]           mem_funct3;
        logic                 alu_src;
        logic                 pc_src;
        logic                 reg_write;
        logic [4:0]           read_reg1;
        logic [4:0]           read_reg2;
        logic [4:0]           write_reg;
        logic                 illegal;
    } entry_t;

    localparam logic [ALU_CTL_W-1:0] ALU_AND     = ALU_CTL_W'(0);
    localparam logic [ALU_CTL_W-1:0] ALU_OR      = ALU_CTL_W'(1);
    localparam logic [ALU_CTL_W-1:0] ALU_ADD     = ALU_CTL_W'(2);
    localparam logic [ALU_CTL_W-1:0] ALU_XOR     = ALU_CTL_W'(3);
    localparam logic [ALU_CTL_W-1:0] ALU_SLL     = ALU_CTL_W'(4);
    localparam logic [ALU_CTL_W-1:0] ALU_SRL     = ALU_CTL_W'(5);
    localparam logic [ALU_CTL_W-1:0] ALU_SUB     = ALU_CTL_W'(6);
    localparam logic [ALU_CTL_W-1:0] ALU_SRA     = ALU_CTL_W'(7);
    localparam logic [ALU_CTL_W-1:0] ALU_GE      = ALU_CTL_W'(8);
    localparam logic [ALU_CTL_W-1:0] ALU_SLT     = ALU_CTL_W'(9);
    localparam logic [ALU_CTL_W-1:0] ALU_CHOOSEB = ALU_CTL_W'(10);
    localparam logic [ALU_CTL_W-1:0] ALU_SLTU    = ALU_CTL_W'(11);
    localparam logic [ALU_CTL_W-1:0] ALU_LT      = ALU_CTL_W'(12);
    localparam logic [ALU_CTL_W-1:0] ALU_LTU     = ALU_CTL_W'(13);
    localparam logic [ALU_CTL_W-1:0] ALU_GEU     = ALU_CTL_W'(14);
    localparam logic [ALU_CTL_W-1:0] ALU_EQ      = ALU_CTL_W'(15);
    localparam logic [ALU_CTL_W-1:0] ALU_NE      = ALU_CTL_W'(16);
    localparam logic [ALU_CTL_W-1:0] ALU_MUL     = ALU_CTL_W'(20);
    localparam logic [ALU_CTL_W-1:0] ALU_ZERO    = ALU_CTL_W'(31);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    occ_t   r_state, w_nextState;
    entry_t r_e0, r_e1, w_dec;
    logic   w_push, w_pop, w_legal, w_writesRd;

    logic [31:0]     w_ir;
    logic [6:0]      w_opcode, w_funct7;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_immI, w_immS, w_immB, w_immU, w_immJ;

    assign w_ir     = bus.instr_raw;
    assign w_opcode = w_ir[6:0];
    assign w_funct3 = w_ir[14:12];
    assign w_funct7 = w_ir[31:25];

    // Sign extension comes from casting the signed field up to XLEN.
    assign w_immI = XLEN'($signed(w_ir[31:20]));
    assign w_immS = XLEN'($signed({w_ir[31:25], w_ir[11:7]}));
    assign w_immB = XLEN'($signed({w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0}));
    assign w_immU = XLEN'($signed({w_ir[31:12], 12'b0}));
    assign w_immJ = XLEN'($signed({w_ir[31], w_ir[19:12], w_ir[20], w_ir[30:21], 1'b0}));

    // in_ready is a decode of the occupancy register, so it never depends
    // combinationally on out_ready.
    assign bus.in_ready  = (r_state != TWO);
    assign bus.out_valid = (r_state != EMPTY);

    assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        w_dec           = '0;
        w_dec.pc        = bus.pc_in;
        w_dec.read_reg1 = w_ir[19:15];
        w_dec.read_reg2 = w_ir[24:20];
        w_dec.write_reg = w_ir[11:7];
        w_dec.alu_ctl   = ALU_ZERO;
        w_legal         = 1'b1;
        w_writesRd      = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.imm = w_immU; w_dec.alu_ctl = ALU_CHOOSEB;
                w_dec.alu_src = 1'b1; w_writesRd = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.imm = w_immU; w_dec.alu_ctl = ALU_ADD;
                w_dec.alu_src = 1'b1; w_dec.pc_src = 1'b1; w_writesRd = 1'b1;
            end
            OPC_JAL: begin
                w_dec.imm = w_immJ; w_dec.alu_ctl = ALU_CHOOSEB;
                w_dec.alu_src = 1'b1; w_dec.pc_src = 1'b1;
                w_dec.branch_uc = 1'b1; w_dec.branch_relative = 1'b1;
                w_writesRd = 1'b1;
            end
            OPC_JALR: begin
                w_dec.imm = w_immI; w_dec.alu_ctl = ALU_ADD;
                w_dec.alu_src = 1'b1; w_dec.branch_uc = 1'b1;
                w_writesRd = 1'b1;
                w_legal = (w_funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                w_dec.imm = w_immB; w_dec.branch_c = 1'b1;
                w_dec.branch_relative = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.alu_ctl = ALU_EQ;
                    3'b001:  w_dec.alu_ctl = ALU_NE;
                    3'b100:  w_dec.alu_ctl = ALU_LT;
                    3'b101:  w_dec.alu_ctl = ALU_GE;
                    3'b110:  w_dec.alu_ctl = ALU_LTU;
                    3'b111:  w_dec.alu_ctl = ALU_GEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_dec.imm = w_immI; w_dec.alu_ctl = ALU_ADD;
                w_dec.alu_src = 1'b1; w_dec.mem_read = 1'b1;
                w_dec.mem_funct3 = w_funct3; w_writesRd = 1'b1;
                w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                          (w_funct3 != 3'b111);
            end
            OPC_STORE: begin
                w_dec.imm = w_immS; w_dec.alu_ctl = ALU_ADD;
                w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1;
                w_dec.mem_funct3 = w_funct3;
                w_legal = (w_funct3 < 3'b011);
            end
            OPC_OPIMM: begin
                w_dec.imm = w_immI; w_dec.alu_src = 1'b1; w_writesRd = 1'b1;
                case (w_funct3)
                    3'b000: w_dec.alu_ctl = ALU_ADD;
                    3'b010: w_dec.alu_ctl = ALU_SLT;
                    3'b011: w_dec.alu_ctl = ALU_SLTU;
                    3'b100: w_dec.alu_ctl = ALU_XOR;
                    3'b110: w_dec.alu_ctl = ALU_OR;
                    3'b111: w_dec.alu_ctl = ALU_AND;
                    3'b001: begin
                        w_dec.alu_ctl = ALU_SLL;
                        w_legal = (w_funct7 == 7'b0000000);
                    end
                    default: begin
                        // funct3 101: funct7 selects logical or arithmetic shift.
                        if (w_funct7 == 7'b0000000)      w_dec.alu_ctl = ALU_SRL;
                        else if (w_funct7 == 7'b0100000) w_dec.alu_ctl = ALU_SRA;
                        else                             w_legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                w_writesRd = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  w_dec.alu_ctl = ALU_ADD;
                        3'b001:  w_dec.alu_ctl = ALU_SLL;
                        3'b010:  w_dec.alu_ctl = ALU_SLT;
                        3'b011:  w_dec.alu_ctl = ALU_SLTU;
                        3'b100:  w_dec.alu_ctl = ALU_XOR;
                        3'b101:  w_dec.alu_ctl = ALU_SRL;
                        3'b110:  w_dec.alu_ctl = ALU_OR;
                        default: w_dec.alu_ctl = ALU_AND;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000)      w_dec.alu_ctl = ALU_SUB;
                    else if (w_funct3 == 3'b101) w_dec.alu_ctl = ALU_SRA;
                    else                         w_legal = 1'b0;
                end else if (ENABLE_M && (w_funct7 == 7'b0000001)) begin
                    // MUL..REMU are consecutive codes in funct3 order.
                    w_dec.alu_ctl = ALU_MUL + ALU_CTL_W'(w_funct3);
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.reg_write = w_writesRd & (w_ir[11:7] != 5'd0);
        if (!w_legal) begin
            w_dec           = '0;
            w_dec.pc        = bus.pc_in;
            w_dec.read_reg1 = w_ir[19:15];
            w_dec.read_reg2 = w_ir[24:20];
            w_dec.write_reg = w_ir[11:7];
            w_dec.alu_ctl   = ALU_ZERO;
            w_dec.illegal   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_push) w_nextState = ONE;
                ONE: begin
                    if (w_push && !w_pop)      w_nextState = TWO;
                    else if (!w_push && w_pop) w_nextState = EMPTY;
                end
                TWO:     if (w_pop) w_nextState = ONE;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    // Entry 0 is always the head; a pop either promotes entry 1 or, when the
    // buffer held only one entry, takes the simultaneously pushed bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0         <= '0;
            r_e0.alu_ctl <= ALU_ZERO;
            r_e1         <= '0;
            r_e1.alu_ctl <= ALU_ZERO;
        end else if (w_pop) begin
            if (r_state == TWO) r_e0 <= r_e1;
            else if (w_push)    r_e0 <= w_dec;
        end else if (w_push) begin
            if (r_state == EMPTY) r_e0 <= w_dec;
            else                  r_e1 <= w_dec;
        end
    end

    assign bus.pc              = r_e0.pc;
    assign bus.imm             = r_e0.imm;
    assign bus.alu_ctl         = r_e0.alu_ctl;
    assign bus.branch_c        = r_e0.branch_c;
    assign bus.branch_uc       = r_e0.branch_uc;
    assign bus.branch_relative = r_e0.branch_relative;
    assign bus.mem_read        = r_e0.mem_read;
    assign bus.mem_write       = r_e0.mem_write;
    assign bus.mem_funct3      = r_e0.mem_funct3;
    assign bus.alu_src         = r_e0.alu_src;
    assign bus.pc_src          = r_e0.pc_src;
    assign bus.reg_write       = r_e0.reg_write;
    assign bus.read_reg1       = r_e0.read_reg1;
    assign bus.read_reg2       = r_e0.read_reg2;
    assign bus.write_reg       = r_e0.write_reg;
    assign bus.illegal         = r_e0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage. dutA is built without the M extension,
// dutM with it; both share clock and reset. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nFails = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .ALU_CTL_W(5)) busA ();
    decode_stage_if #(.XLEN(32), .ALU_CTL_W(5)) busM ();

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ALU_CTL_W(5)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA.slave)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ALU_CTL_W(5)) dutM (
        .clk(clk), .rst_n(rst_n), .bus(busM.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction to dutA for a single cycle.
    task automatic pushA(input logic [31:0] instr, input logic [31:0] pcv);
        busA.in_valid  = 1'b1;
        busA.instr_raw = instr;
        busA.pc_in     = pcv;
        step();
        busA.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        busA.in_valid = 1'b0; busA.instr_raw = '0; busA.pc_in = '0;
        busA.flush = 1'b0; busA.out_ready = 1'b0;
        busM.in_valid = 1'b0; busM.instr_raw = '0; busM.pc_in = '0;
        busM.flush = 1'b0; busM.out_ready = 1'b0;
        #12;
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid got %0h exp 0", busA.out_valid); end
        nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready got %0h exp 1", busA.in_ready); end
        nChecks++; if (busA.alu_ctl !== 5'd31) begin nFails++; $display("[TB] FAIL reset_alu_ctl got %0d exp 31", busA.alu_ctl); end
        nChecks++; if (busA.imm !== 32'h0) begin nFails++; $display("[TB] FAIL reset_imm got %h exp 0", busA.imm); end
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL reset_reg_write got %0h exp 0", busA.reg_write); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_midstream();
        busA.out_ready = 1'b0;
        pushA(32'h00500093, 32'h200);
        pushA(32'h00A00113, 32'h204);
        nChecks++; if (busA.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL mid_full_in_ready got %0h exp 0", busA.in_ready); end
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_out_valid got %0h exp 0", busA.out_valid); end
        nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL mid_rst_in_ready got %0h exp 1", busA.in_ready); end
        nChecks++; if (busA.alu_ctl !== 5'd31) begin nFails++; $display("[TB] FAIL mid_rst_alu_ctl got %0d exp 31", busA.alu_ctl); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pushA(32'h00500093, 32'h300);
        nChecks++; if (busA.out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL addi_out_valid got %0h exp 1", busA.out_valid); end
        nChecks++; if (busA.imm !== 32'd5) begin nFails++; $display("[TB] FAIL addi_imm got %h exp 5", busA.imm); end
        nChecks++; if (busA.alu_ctl !== 5'd2) begin nFails++; $display("[TB] FAIL addi_alu_ctl got %0d exp 2", busA.alu_ctl); end
        nChecks++; if (busA.reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL addi_reg_write got %0h exp 1", busA.reg_write); end
        nChecks++; if (busA.write_reg !== 5'd1) begin nFails++; $display("[TB] FAIL addi_write_reg got %0d exp 1", busA.write_reg); end
        nChecks++; if (busA.pc !== 32'h300) begin nFails++; $display("[TB] FAIL addi_pc got %h exp 300", busA.pc); end
        busA.out_ready = 1'b1;
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL addi_drain got %0h exp 0", busA.out_valid); end
    endtask

    task automatic test_back_pressure();
        busA.out_ready = 1'b0;
        pushA(32'hFE000EE3, 32'h100);
        nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL bp_one_in_ready got %0h exp 1", busA.in_ready); end
        pushA(32'h0000006F, 32'h104);
        nChecks++; if (busA.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_two_in_ready got %0h exp 0", busA.in_ready); end
        step();
        nChecks++; if (busA.pc !== 32'h100) begin nFails++; $display("[TB] FAIL bp_hold_pc got %h exp 100", busA.pc); end
        nChecks++; if (busA.branch_c !== 1'b1) begin nFails++; $display("[TB] FAIL beq_branch_c got %0h exp 1", busA.branch_c); end
        nChecks++; if (busA.alu_ctl !== 5'd15) begin nFails++; $display("[TB] FAIL beq_alu_ctl got %0d exp 15", busA.alu_ctl); end
        nChecks++; if (busA.imm !== 32'hFFFFFFFC) begin nFails++; $display("[TB] FAIL beq_imm got %h exp fffffffc", busA.imm); end
        nChecks++; if (busA.alu_src !== 1'b0) begin nFails++; $display("[TB] FAIL beq_alu_src got %0h exp 0", busA.alu_src); end
        busA.out_ready = 1'b1;
        step();
        nChecks++; if (busA.pc !== 32'h104) begin nFails++; $display("[TB] FAIL jal_pc got %h exp 104", busA.pc); end
        nChecks++; if (busA.branch_uc !== 1'b1) begin nFails++; $display("[TB] FAIL jal_branch_uc got %0h exp 1", busA.branch_uc); end
        nChecks++; if (busA.alu_ctl !== 5'd10) begin nFails++; $display("[TB] FAIL jal_alu_ctl got %0d exp 10", busA.alu_ctl); end
        nChecks++; if (busA.pc_src !== 1'b1) begin nFails++; $display("[TB] FAIL jal_pc_src got %0h exp 1", busA.pc_src); end
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL jal_x0_reg_write got %0h exp 0", busA.reg_write); end
        nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL jal_in_ready got %0h exp 1", busA.in_ready); end
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_drain got %0h exp 0", busA.out_valid); end
    endtask

    task automatic test_back_to_back();
        busA.out_ready = 1'b1;
        busA.in_valid  = 1'b1;
        busA.instr_raw = 32'h00000093;
        busA.pc_in     = 32'h1000;
        step();
        for (int k = 1; k <= 20; k++) begin
            busA.instr_raw = (32'(k) << 20) | 32'h00000093;
            busA.pc_in     = 32'h1000 + 32'(4 * k);
            step();
            nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_in_ready k=%0d got %0h exp 1", k, busA.in_ready); end
            nChecks++; if (busA.pc !== 32'h1000 + 32'(4 * k)) begin nFails++; $display("[TB] FAIL b2b_pc k=%0d got %h exp %h", k, busA.pc, 32'h1000 + 32'(4 * k)); end
            nChecks++; if (busA.imm !== 32'(k)) begin nFails++; $display("[TB] FAIL b2b_imm k=%0d got %h exp %h", k, busA.imm, 32'(k)); end
        end
        busA.in_valid = 1'b0;
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_drain got %0h exp 0", busA.out_valid); end
    endtask

    task automatic test_flush();
        busA.out_ready = 1'b0;
        pushA(32'h00100093, 32'h400);
        pushA(32'h00200093, 32'h404);
        busA.in_valid  = 1'b1;
        busA.instr_raw = 32'h00300093;
        busA.pc_in     = 32'h408;
        busA.flush     = 1'b1;
        step();
        busA.flush = 1'b0; busA.in_valid = 1'b0;
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush2_out_valid got %0h exp 0", busA.out_valid); end
        nChecks++; if (busA.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL flush2_in_ready got %0h exp 1", busA.in_ready); end
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush2_ghost got %0h exp 0", busA.out_valid); end
        pushA(32'h00100093, 32'h500);
        busA.in_valid  = 1'b1;
        busA.instr_raw = 32'h00300093;
        busA.pc_in     = 32'h504;
        busA.flush     = 1'b1;
        step();
        busA.flush = 1'b0; busA.in_valid = 1'b0;
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush1_dropped_push got %0h exp 0", busA.out_valid); end
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush1_ghost got %0h exp 0", busA.out_valid); end
    endtask

    task automatic test_mext();
        busA.out_ready = 1'b1;
        pushA(32'h022081B3, 32'h600);
        nChecks++; if (busA.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL mul_noM_illegal got %0h exp 1", busA.illegal); end
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL mul_noM_reg_write got %0h exp 0", busA.reg_write); end
        nChecks++; if (busA.alu_ctl !== 5'd31) begin nFails++; $display("[TB] FAIL mul_noM_alu_ctl got %0d exp 31", busA.alu_ctl); end
        step();
        busM.out_ready = 1'b1;
        busM.in_valid  = 1'b1;
        busM.instr_raw = 32'h022081B3;
        busM.pc_in     = 32'h600;
        step();
        busM.in_valid = 1'b0;
        nChecks++; if (busM.alu_ctl !== 5'd20) begin nFails++; $display("[TB] FAIL mul_M_alu_ctl got %0d exp 20", busM.alu_ctl); end
        nChecks++; if (busM.reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL mul_M_reg_write got %0h exp 1", busM.reg_write); end
        nChecks++; if (busM.illegal !== 1'b0) begin nFails++; $display("[TB] FAIL mul_M_illegal got %0h exp 0", busM.illegal); end
        nChecks++; if (busM.write_reg !== 5'd3) begin nFails++; $display("[TB] FAIL mul_M_write_reg got %0d exp 3", busM.write_reg); end
        step();
    endtask

    task automatic test_misc_decode();
        busA.out_ready = 1'b1;
        pushA(32'h00208033, 32'h700);
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL add_x0_reg_write got %0h exp 0", busA.reg_write); end
        nChecks++; if (busA.alu_ctl !== 5'd2) begin nFails++; $display("[TB] FAIL add_x0_alu_ctl got %0d exp 2", busA.alu_ctl); end
        pushA(32'hFFFFF2B7, 32'h704);
        nChecks++; if (busA.imm !== 32'hFFFFF000) begin nFails++; $display("[TB] FAIL lui_imm got %h exp fffff000", busA.imm); end
        nChecks++; if (busA.alu_ctl !== 5'd10) begin nFails++; $display("[TB] FAIL lui_alu_ctl got %0d exp 10", busA.alu_ctl); end
        nChecks++; if (busA.reg_write !== 1'b1) begin nFails++; $display("[TB] FAIL lui_reg_write got %0h exp 1", busA.reg_write); end
        pushA(32'h0000007F, 32'h708);
        nChecks++; if (busA.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL op7f_illegal got %0h exp 1", busA.illegal); end
        nChecks++; if (busA.mem_write !== 1'b0) begin nFails++; $display("[TB] FAIL op7f_mem_write got %0h exp 0", busA.mem_write); end
        nChecks++; if (busA.alu_ctl !== 5'd31) begin nFails++; $display("[TB] FAIL op7f_alu_ctl got %0d exp 31", busA.alu_ctl); end
        pushA(32'h0020A423, 32'h70C);
        nChecks++; if (busA.mem_write !== 1'b1) begin nFails++; $display("[TB] FAIL sw_mem_write got %0h exp 1", busA.mem_write); end
        nChecks++; if (busA.imm !== 32'd8) begin nFails++; $display("[TB] FAIL sw_imm got %h exp 8", busA.imm); end
        nChecks++; if (busA.mem_funct3 !== 3'd2) begin nFails++; $display("[TB] FAIL sw_funct3 got %0d exp 2", busA.mem_funct3); end
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL sw_reg_write got %0h exp 0", busA.reg_write); end
        pushA(32'hFFC12083, 32'h710);
        nChecks++; if (busA.mem_read !== 1'b1) begin nFails++; $display("[TB] FAIL lw_mem_read got %0h exp 1", busA.mem_read); end
        nChecks++; if (busA.imm !== 32'hFFFFFFFC) begin nFails++; $display("[TB] FAIL lw_imm got %h exp fffffffc", busA.imm); end
        nChecks++; if (busA.read_reg1 !== 5'd2) begin nFails++; $display("[TB] FAIL lw_read_reg1 got %0d exp 2", busA.read_reg1); end
        pushA(32'h4010D093, 32'h714);
        nChecks++; if (busA.alu_ctl !== 5'd7) begin nFails++; $display("[TB] FAIL srai_alu_ctl got %0d exp 7", busA.alu_ctl); end
        pushA(32'h40109093, 32'h718);
        nChecks++; if (busA.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL slli_bad_illegal got %0h exp 1", busA.illegal); end
        nChecks++; if (busA.reg_write !== 1'b0) begin nFails++; $display("[TB] FAIL slli_bad_reg_write got %0h exp 0", busA.reg_write); end
        step();
        nChecks++; if (busA.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL misc_drain got %0h exp 0", busA.out_valid); end
    endtask

    initial begin
        $display("[TB] decode_stage directed test start");
        test_reset();
        test_reset_midstream();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_mext();
        test_misc_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
